spmv_bench_ctrl: RTL and testbench

Benchmark sequencer for the SpMV calc kernel. It launches the kernel a configured number of times back to back and measures each run in clock cycles, from launch pulse to the rising edge of done. It accumulates last/min/max/total statistics and enforces an optional per-run timeout and a host abort. It sits between the host control registers and the kernel's start/done handshake, and provides the sequencing and statistics around the kernel's cycle counter.

---
 rtl/spmv_bench_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spmv_bench_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_bench_ctrl.sv
// spmv_bench_ctrl: launches the SpMV kernel N times and keeps
// last/min/max/total cycle statistics with timeout and abort.
module spmv_bench_ctrl #(
  parameter int CNT_W  = 64,
  parameter int ITER_W = 16,
  parameter int TMO_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  output logic              kernel_start,
  input  logic              kernel_done,
  output logic              busy,
  output logic              result_valid,
  output logic [ITER_W-1:0] iter_done,
  output logic [CNT_W-1:0]  last_cycles,
  output logic [CNT_W-1:0]  min_cycles,
  output logic [CNT_W-1:0]  max_cycles,
  output logic [CNT_W-1:0]  total_cycles,
  output logic              timeout_flag,
  output logic              aborted_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              done_ff_q;
  logic              ks_q, ks_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ITER_W-1:0] idone_q, idone_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic              tflag_q, tflag_d;
  logic              aflag_q, aflag_d;

  logic              rise;
  logic [CNT_W-1:0]  k_inc;
  logic [CNT_W-1:0]  tmo_ext;
  logic [CNT_W:0]    tsum;
  logic [ITER_W-1:0] idone_inc;

  assign rise      = kernel_done & ~done_ff_q;
  assign k_inc     = (&k_q) ? k_q : k_q + CNT_W'(1);
  assign tmo_ext   = CNT_W'(tmo_q);
  assign tsum      = {1'b0, tot_q} + {1'b0, k_inc};
  assign idone_inc = idone_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    tmo_d   = tmo_q;
    k_d     = k_q;
    idone_d = idone_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    tot_d   = tot_q;
    tflag_d = tflag_q;
    aflag_d = aflag_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          iters_d = cfg_iters;
          tmo_d   = cfg_timeout;
          idone_d = '0;
          last_d  = '0;
          min_d   = '0;
          max_d   = '0;
          tot_d   = '0;
          tflag_d = 1'b0;
          aflag_d = 1'b0;
          state_d = (cfg_iters == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        k_d = '0;
        if (cmd_abort) begin
          aflag_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        k_d = k_inc;
        if (cmd_abort) begin
          aflag_d = 1'b1;
          state_d = S_DONE;
        end else if (rise) begin
          last_d  = k_inc;
          tot_d   = tsum[CNT_W] ? '1 : tsum[CNT_W-1:0];
          max_d   = (k_inc > max_q) ? k_inc : max_q;
          min_d   = (idone_q == '0 || k_inc < min_q) ? k_inc : min_q;
          idone_d = idone_inc;
          state_d = (idone_inc == iters_q) ? S_DONE : S_LAUNCH;
        end else if (tmo_q != '0 && k_inc == tmo_ext) begin
          tflag_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ks_d = (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_ff_q <= 1'b0;
      ks_q      <= 1'b0;
      iters_q   <= '0;
      tmo_q     <= '0;
      k_q       <= '0;
      idone_q   <= '0;
      last_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      tot_q     <= '0;
      tflag_q   <= 1'b0;
      aflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_ff_q <= kernel_done;
      ks_q      <= ks_d;
      iters_q   <= iters_d;
      tmo_q     <= tmo_d;
      k_q       <= k_d;
      idone_q   <= idone_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      tot_q     <= tot_d;
      tflag_q   <= tflag_d;
      aflag_q   <= aflag_d;
    end
  end

  assign kernel_start = ks_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign iter_done    = idone_q;
  assign last_cycles  = last_q;
  assign min_cycles   = min_q;
  assign max_cycles   = max_q;
  assign total_cycles = tot_q;
  assign timeout_flag = tflag_q;
  assign aborted_flag = aflag_q;

endmodule

// File: tb/tb_spmv_bench_ctrl.sv
// Bench for spmv_bench_ctrl: kernel model driven per cycle, results
// compared to statistics computed from the list of run delays.
module tb_spmv_bench_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_iters = '0;
  logic [31:0] cfg_timeout = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic        kernel_start;
  logic        kdone = 1'b0;
  logic        busy;
  logic        result_valid;
  logic [15:0] iter_done;
  logic [63:0] last_cycles, min_cycles, max_cycles, total_cycles;
  logic        timeout_flag, aborted_flag;

  spmv_bench_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_iters    (cfg_iters),
    .cfg_timeout  (cfg_timeout),
    .cmd_start    (cmd_start),
    .cmd_abort    (cmd_abort),
    .kernel_start (kernel_start),
    .kernel_done  (kdone),
    .busy         (busy),
    .result_valid (result_valid),
    .iter_done    (iter_done),
    .last_cycles  (last_cycles),
    .min_cycles   (min_cycles),
    .max_cycles   (max_cycles),
    .total_cycles (total_cycles),
    .timeout_flag (timeout_flag),
    .aborted_flag (aborted_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cycle = 0;
  int ks_cnt = 0;
  int rv_cnt = 0;
  int rem = -1;
  bit tie = 0;
  int dq[$];
  int plan[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: kernel model, pulse cleanup and output monitors.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    if (kernel_start) begin
      ks_cnt++;
      rem = (dq.size() > 0) ? dq.pop_front() : -1;
      if (!tie) kdone = 1'b0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) kdone = 1'b1;
    end
    if (result_valid) rv_cnt++;
  endtask

  task automatic run_bench(input int iters, input int tmo, input bit spam);
    int t0, ks0, rv0, lat, e_lat, e_ks, e_rec;
    longint e_last, e_min, e_max, e_tot;
    bit e_tf, got;
    e_lat = 1; e_ks = 0; e_rec = 0; e_tf = 0;
    e_last = 0; e_min = 0; e_max = 0; e_tot = 0;
    for (int i = 0; i < iters && !e_tf; i++) begin
      int d;
      d = plan[i];
      e_ks++;
      if (tmo != 0 && (d < 0 || d > tmo)) begin
        e_tf = 1;
        e_lat += tmo + 1;
      end else begin
        e_lat += d + 1;
        e_last = d;
        e_tot += d;
        if (e_rec == 0 || d < e_min) e_min = d;
        if (d > e_max) e_max = d;
        e_rec++;
      end
    end
    dq = plan;
    ks0 = ks_cnt;
    rv0 = rv_cnt;
    cfg_iters = 16'(iters);
    cfg_timeout = 32'(tmo);
    cmd_start = 1'b1;
    t0 = cycle;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      cyc();
      if (result_valid) got = 1;
      else if (spam && busy && i % 7 == 3) begin
        cmd_start = 1'b1;
        cfg_iters = '0;
        cfg_timeout = 32'd1;
      end
    end
    lat = cycle - t0;
    chk("rv_seen", 64'(got), 64'd1);
    chk("rv_latency", 64'(lat), 64'(e_lat));
    chk("kstart_count", 64'(ks_cnt - ks0), 64'(e_ks));
    chk("iter_done", 64'(iter_done), 64'(e_rec));
    chk("last", last_cycles, e_last);
    chk("min", min_cycles, e_min);
    chk("max", max_cycles, e_max);
    chk("total", total_cycles, e_tot);
    chk("timeout_flag", 64'(timeout_flag), 64'(e_tf));
    chk("aborted_flag", 64'(aborted_flag), 64'd0);
    cyc();
    chk("busy_after", 64'(busy), 64'd0);
    chk("rv_count", 64'(rv_cnt - rv0), 64'd1);
  endtask

  initial begin
    int ks0, rv0, t0;
    bit hit;
    cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_kstart", 64'(kernel_start), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_iter", 64'(iter_done), 64'd0);
    chk("rst_stats", last_cycles | min_cycles | max_cycles | total_cycles, 64'd0);
    chk("rst_flags", 64'({timeout_flag, aborted_flag}), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    plan = '{10, 20, 15};
    run_bench(3, 0, 1);
    plan = '{5, -1, 3, 3};
    run_bench(4, 8, 1);
    plan = '{8};
    run_bench(1, 8, 0);
    plan = '{};
    run_bench(0, 0, 0);

    // abort coinciding with the second done edge
    plan = '{6, 4};
    dq = plan;
    ks0 = ks_cnt;
    cfg_iters = 16'd2;
    cfg_timeout = '0;
    cmd_start = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc();
      if (ks_cnt == ks0 + 2 && kdone) hit = 1;
    end
    chk("abort_edge_reached", 64'(hit), 64'd1);
    cmd_abort = 1'b1;
    cyc();
    chk("abort_rv", 64'(result_valid), 64'd1);
    chk("abort_flag", 64'(aborted_flag), 64'd1);
    chk("abort_iter", 64'(iter_done), 64'd1);
    chk("abort_last", last_cycles, 64'd6);
    chk("abort_total", total_cycles, 64'd6);
    cyc();

    // done tied high: no edge ever, abort ends it
    tie = 1;
    kdone = 1'b1;
    dq.delete();
    cfg_iters = 16'd2;
    cmd_start = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("tie_busy", 64'(busy), 64'd1);
    chk("tie_iter", 64'(iter_done), 64'd0);
    cmd_abort = 1'b1;
    cyc();
    chk("tie_rv", 64'(result_valid), 64'd1);
    chk("tie_abort", 64'(aborted_flag), 64'd1);
    chk("tie_min", min_cycles, 64'd0);
    tie = 0;
    kdone = 1'b0;
    cyc();
    cyc();

    // asynchronous reset while kernel_start is high
    plan = '{3, 3, 3};
    dq = plan;
    ks0 = ks_cnt;
    cfg_iters = 16'd3;
    cmd_start = 1'b1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      if (ks_cnt == ks0 + 2) hit = 1;
    end
    chk("rst_mid_reached", 64'(hit & kernel_start), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("amid_kstart", 64'(kernel_start), 64'd0);
    chk("amid_busy", 64'(busy), 64'd0);
    chk("amid_iter", 64'(iter_done), 64'd0);
    chk("amid_stats", last_cycles | max_cycles | total_cycles, 64'd0);
    rem = -1;
    kdone = 1'b0;
    dq.delete();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    plan = '{3};
    run_bench(1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int it, tmo;
      it = int'($urandom_range(1, 4));
      tmo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 12)) : 0;
      plan.delete();
      for (int i = 0; i < it; i++) plan.push_back(int'($urandom_range(1, 12)));
      run_bench(it, tmo, 1);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
